// File: rtl/status_hazard_ctrl_pkg.sv
// ARM condition-field constants, NZCV bit positions and hazard FSM states
// shared by the status hazard controller and the branch unit.
package arm_cond_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int unsigned N_BIT = 3;
  localparam int unsigned Z_BIT = 2;
  localparam int unsigned C_BIT = 1;
  localparam int unsigned V_BIT = 0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HAZ   = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/status_hazard_ctrl_if.sv
// ID->EXE issue handshake and registered EXE-side issue results.
interface status_hazard_ctrl_if;
  logic       id_valid;
  logic [3:0] id_cond;
  logic       id_s;
  logic       id_ready;
  logic       ex_valid;
  logic       ex_cond_pass;
  logic       ex_s;

  modport master (
    output id_valid, id_cond, id_s,
    input  id_ready, ex_valid, ex_cond_pass, ex_s
  );

  modport slave (
    input  id_valid, id_cond, id_s,
    output id_ready, ex_valid, ex_cond_pass, ex_s
  );
endinterface

// File: rtl/status_hazard_ctrl_cond_check.sv
// Combinational ARM condition evaluation against an NZCV nibble.
module cond_check
  import arm_cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  always_comb begin
    n = nzcv[N_BIT];
    z = nzcv[Z_BIT];
    c = nzcv[C_BIT];
    v = nzcv[V_BIT];
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/status_hazard_ctrl.sv
// Issue-side NZCV hazard controller: stalls conditional issue behind pending
// flag writers and produces the registered EXE valid / status-write enable.
module status_hazard_ctrl
  import arm_cond_pkg::*;
#(
  parameter int unsigned MAX_PENDING = 3,
  parameter int unsigned CNT_W       = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  status_hazard_ctrl_if.slave  bus,
  input  logic [3:0]           status_bits,
  input  logic                 flag_wr,
  input  logic                 flush,
  output logic [CNT_W-1:0]     pending_cnt,
  output logic [1:0]           state_o,
  output logic                 err_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);

  state_t           state;
  state_t           state_next;
  logic             pass;
  logic             ready;
  logic             accept;
  logic             inc;
  logic             dec;
  logic [CNT_W-1:0] cnt_next;

  cond_check u_cond_check (
    .cond (bus.id_cond),
    .nzcv (status_bits),
    .pass (pass)
  );

  // No bypass of a same-cycle flag_wr: conditional issue waits on the registered count.
  always_comb begin
    ready = 1'b1;
    if (state == FLUSH || flush)
      ready = 1'b0;
    if (bus.id_cond != COND_AL && pending_cnt != '0)
      ready = 1'b0;
    if (bus.id_s && pending_cnt == CNT_MAX)
      ready = 1'b0;
  end

  assign accept = bus.id_valid && ready;
  assign inc    = accept && bus.id_s && pass;
  assign dec    = flag_wr;

  always_comb begin
    cnt_next = pending_cnt;
    if (flush) begin
      cnt_next = '0;
    end else begin
      case ({inc, dec})
        2'b10:   cnt_next = pending_cnt + CNT_W'(1);
        2'b01:   if (pending_cnt != '0) cnt_next = pending_cnt - CNT_W'(1);
        default: cnt_next = pending_cnt;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst)
      state <= RUN;
    else
      state <= state_next;
  end

  // FSM next state; FLUSH always exits to RUN because the count is cleared with it
  always_comb begin
    state_next = state;
    if (flush)
      state_next = FLUSH;
    else if (cnt_next != '0)
      state_next = HAZ;
    else
      state_next = RUN;
  end

  // FSM outputs
  always_comb begin
    bus.id_ready = ready;
    state_o      = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_cnt   <= '0;
      err_underflow <= 1'b0;
    end else begin
      pending_cnt <= cnt_next;
      if (!flush && flag_wr && pending_cnt == '0)
        err_underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      bus.ex_valid     <= 1'b0;
      bus.ex_cond_pass <= 1'b0;
      bus.ex_s         <= 1'b0;
    end else begin
      bus.ex_valid     <= accept;
      bus.ex_cond_pass <= accept && pass;
      bus.ex_s         <= inc;
    end
  end

endmodule
